adder_acc_pipe: RTL

- Parametrised, pipelined successor to the team's registered multi-operand adder.
- Sums NOPS packed W-bit operands plus a carry-in, with a valid/ready handshake on both sides and an optional running-accumulate mode.
- Produces the sum, a zero flag and a sticky overflow flag.
- Sits between operand-producing datapath blocks and downstream consumers that can apply backpressure.

---
 rtl/adder_acc_pipe_if.sv | 30 +++
 rtl/adder_acc_pipe.sv | 138 +++++++++++++
 2 files changed

// File: rtl/adder_acc_pipe_if.sv
// Operand/result bundle for adder_acc_pipe: input beat side plus result side.
// slave  : the adder's view (takes beats and out_ready, drives in_ready/results).
// master : the producer/consumer view (drives beats and out_ready).
interface adder_acc_pipe_if #(
  parameter int NOPS = 4,
  parameter int W    = 8,
  parameter int SW   = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [NOPS*W-1:0] ops;
  logic              cin;
  logic              in_acc;
  logic              in_clr;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     sum;
  logic              sum_zero;
  logic              ovf;

  modport slave (
    input  in_valid, ops, cin, in_acc, in_clr, out_ready,
    output in_ready, out_valid, sum, sum_zero, ovf
  );

  modport master (
    output in_valid, ops, cin, in_acc, in_clr, out_ready,
    input  in_ready, out_valid, sum, sum_zero, ovf
  );
endinterface

// File: rtl/adder_acc_pipe.sv
// Pipelined NOPS-operand adder with carry-in, optional running accumulate, zero and sticky overflow flags.
// Latency 2 cycles (S1 pair sums, S2 result register); throughput 1 beat per cycle.
// Backpressure: whole pipeline stalls while out_valid && !out_ready; in_ready = !out_valid || out_ready.
//
// Ports: clk, rst_n (async active-low); bus (adder_acc_pipe_if.slave) carries
//   in_valid/in_ready/ops/cin/in_acc/in_clr on the input side and
//   out_valid/out_ready/sum/sum_zero/ovf on the result side.
// Build option: define ADDER_ACC_SAT_EN to saturate sum/accumulator at 2^SW-1
//   on accumulate overflow instead of wrapping modulo 2^SW.
module adder_acc_pipe #(
  parameter int NOPS = 4,   // even, >= 2
  parameter int W    = 8,
  parameter int SW   = 12   // >= W + clog2(NOPS) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_acc_pipe_if.slave    bus
);
  localparam int NP = NOPS / 2;

  logic adv;

  // S1: pair sums and beat flags
  logic                s1_vld_q, s1_vld_d;
  logic                s1_acc_q, s1_acc_d;
  logic                s1_clr_q, s1_clr_d;
  logic [NP-1:0][W:0]  s1_pair_q, s1_pair_d;

  // S2: output register plus accumulator state
  logic                out_vld_q, out_vld_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic                sum_zero_q, sum_zero_d;
  logic                ovf_q, ovf_d;
  logic [SW-1:0]       acc_q, acc_d;
  logic                ovf_acc_q, ovf_acc_d;   // sticky overflow of the current accumulation

  logic [SW-1:0]       beat_sum;
  logic [SW:0]         full;

  assign adv           = !out_vld_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_vld_q;
  assign bus.sum       = sum_q;
  assign bus.sum_zero  = sum_zero_q;
  assign bus.ovf       = ovf_q;

  // S1 next state: only an accepted beat loads data; a bubble just clears the valid.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_acc_d  = s1_acc_q;
    s1_clr_d  = s1_clr_q;
    s1_pair_d = s1_pair_q;
    if (adv) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_acc_d = bus.in_acc;
        // clear has no meaning outside an accumulate beat, so drop it here
        s1_clr_d = bus.in_acc & bus.in_clr;
        for (int i = 0; i < NP; i++) begin
          s1_pair_d[i] = {1'b0, bus.ops[2*i*W +: W]} + {1'b0, bus.ops[(2*i+1)*W +: W]};
        end
        s1_pair_d[0] = s1_pair_d[0] + {{W{1'b0}}, bus.cin};
      end
    end
  end

  // Beat sum: pair sums zero-extended to SW bits; SW is sized so this never overflows.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NP; i++) begin
      beat_sum = beat_sum + {{(SW-W-1){1'b0}}, s1_pair_q[i]};
    end
  end

  // One extra bit catches the accumulate carry-out.
  assign full = {1'b0, acc_q} + {1'b0, beat_sum};

  // S2 next state: result selection and accumulator update for the beat leaving S1.
  always_comb begin
    out_vld_d  = out_vld_q;
    sum_d      = sum_q;
    sum_zero_d = sum_zero_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    ovf_acc_d  = ovf_acc_q;
    if (adv) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        if (!s1_acc_q) begin
          // plain add: accumulator and its sticky bit untouched
          sum_d = beat_sum;
          ovf_d = 1'b0;
        end else if (s1_clr_q) begin
          sum_d     = beat_sum;
          acc_d     = beat_sum;
          ovf_acc_d = 1'b0;
          ovf_d     = 1'b0;
        end else begin
`ifdef ADDER_ACC_SAT_EN
          sum_d = full[SW] ? {SW{1'b1}} : full[SW-1:0];
`else
          sum_d = full[SW-1:0];
`endif
          acc_d     = sum_d;
          ovf_acc_d = ovf_acc_q | full[SW];
          ovf_d     = ovf_acc_d;
        end
        sum_zero_d = (sum_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_acc_q   <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_pair_q  <= '0;
      out_vld_q  <= 1'b0;
      sum_q      <= '0;
      sum_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      ovf_acc_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_acc_q   <= s1_acc_d;
      s1_clr_q   <= s1_clr_d;
      s1_pair_q  <= s1_pair_d;
      out_vld_q  <= out_vld_d;
      sum_q      <= sum_d;
      sum_zero_q <= sum_zero_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      ovf_acc_q  <= ovf_acc_d;
    end
  end
endmodule
